event_encoder: RTL and testbench

//  Sequential N-to-log2(N) encoder, the inverse of the 2-to-4 address decoder.

---
 rtl/event_encoder.sv | 150 +++++++++++++++
 tb/tb_event_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder.sv
// event_encoder: sequential N-to-log2(N) encoder.
// Catches rising edges on the request lines as sticky pending bits.
// Hands them out one at a time as a binary address over a valid/ready port.
// Optional feature: define ROUND_ROBIN_EN for rotating priority.
// The search then starts after the last granted line.
// Without ROUND_ROBIN_EN, the lowest pending index always wins.
module event_encoder #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [N_REQ-1:0]  req,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [N_REQ-1:0]  pending,
   output logic              overrun
);

   // The output register is the only state: it is either empty or holds a grant.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

   out_state_t        state;
   out_state_t        state_next;
   logic [N_REQ-1:0]  req_q;
   logic [N_REQ-1:0]  req_event;
   logic [N_REQ-1:0]  sel_onehot;
   logic [N_REQ-1:0]  pending_next;
   logic [ADDR_W-1:0] sel_idx;
   logic [ADDR_W-1:0] addr_next;
   logic              sel_found;
   logic              load;
   logic              overrun_next;
`ifdef ROUND_ROBIN_EN
   logic [ADDR_W-1:0] last_grant;
   logic [ADDR_W-1:0] cand;
`endif

   assign req_event = req & ~req_q;
   assign out_valid = (state == FULL);
   assign load      = enable & (~out_valid | out_ready) & (|pending);

`ifdef ROUND_ROBIN_EN
   // Rotating search: scan from the line after the last grant and wrap.
   // Address arithmetic wraps naturally because N_REQ is a power of two.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = last_grant + ADDR_W'(i + 1);
         if (!sel_found && pending[cand]) begin
            sel_idx   = cand;
            sel_found = 1'b1;
         end
      end
   end
`else
   // Fixed priority: the lowest pending index wins.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!sel_found && pending[i]) begin
            sel_idx   = ADDR_W'(i);
            sel_found = 1'b1;
         end
      end
   end
`endif

   // Clear the granted bit and merge new events.
   // An event on the line being granted re-arms that line.
   // An event on any other already-pending line is lost and flagged as overrun.
   always_comb begin
      sel_onehot   = '0;
      if (load) begin
         sel_onehot = ONE_HOT_0 << sel_idx;
      end
      pending_next = (pending & ~sel_onehot) | req_event;
      overrun_next = |(req_event & pending & ~sel_onehot);
   end

   // Output register next state.
   // Load a new grant whenever the slot is free or being consumed.
   // Otherwise empty the slot on a bare handshake.
   always_comb begin
      state_next = state;
      addr_next  = out_addr;
      if (load) begin
         state_next = FULL;
         addr_next  = sel_idx;
      end else if (enable && out_valid && out_ready) begin
         state_next = EMPTY;
      end
   end

   // Output state register; it is frozen entirely while disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= EMPTY;
         out_addr <= '0;
      end else if (enable) begin
         state    <= state_next;
         out_addr <= addr_next;
      end
   end

   // Edge-detect history and pending set; both frozen while disabled.
   // Edges that happen while frozen are seen against the old req_q once enable returns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_q   <= '0;
         pending <= '0;
      end else if (enable) begin
         req_q   <= req;
         pending <= pending_next;
      end
   end

   // Overrun is a single-cycle pulse and always drops while disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (enable) begin
         overrun <= overrun_next;
      end else begin
         overrun <= 1'b0;
      end
   end

`ifdef ROUND_ROBIN_EN
   // Remember the most recent grant so the next search starts just after it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= '0;
      end else if (load) begin
         last_grant <= sel_idx;
      end
   end
`endif

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder (N_REQ = 4).
// Expected grant addresses are queued when requests are driven.
// They are popped as the DUT completes each handshake.
// Expectations follow fixed priority by default and rotating priority under ROUND_ROBIN_EN.
// Every test starts from reset, so the rotating search always begins after index 0.
module tb_event_encoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic [3:0] req;
   logic       out_ready;
   logic       out_valid;
   logic [1:0] out_addr;
   logic [3:0] pending;
   logic       overrun;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] exp_q[$];

   event_encoder #(.N_REQ(4), .ADDR_W(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .req       (req),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_addr  (out_addr),
      .pending   (pending),
      .overrun   (overrun)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where outputs are sampled and inputs are driven.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset_n   = 1'b0;
      enable    = 1'b0;
      req       = 4'b0000;
      out_ready = 1'b0;
      exp_q.delete();
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      enable    = 1'b1;
      req       = 4'b0001;
      out_ready = 1'b0;
      tick;
      n_checks++;
      if (out_valid !== 1'b0 || out_addr !== 2'd0 || pending !== 4'b0000 || overrun !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got valid=%b addr=%0d pend=%b ovr=%b, want all 0",
                  out_valid, out_addr, pending, overrun);
      end
      reset_n = 1'b1;
      tick;
      n_checks++;
      if (pending !== 4'b0001) begin
         n_fail++;
         $display("[TB] FAIL reset_req_high: got pend=%b, want 0001", pending);
      end
   endtask

   task automatic test_single_event;
      do_reset;
      enable    = 1'b1;
      out_ready = 1'b1;
      req       = 4'b0100;
      exp_q.push_back(2'd2);
      tick;
      n_checks++;
      if (pending !== 4'b0100 || out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL t1_capture: got pend=%b valid=%b, want pend=0100 valid=0", pending, out_valid);
      end
      req = 4'b0000;
      tick;
      while (exp_q.size() > 0) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL t1_grant: got valid=%b addr=%0d, want valid=1 addr=%0d", out_valid, out_addr, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick;
      end
      n_checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL t1_idle: got valid=%b pend=%b, want valid=0 pend=0000", out_valid, pending);
      end
   endtask

   task automatic test_stall_priority;
      logic [1:0] held;
      do_reset;
      enable    = 1'b1;
      out_ready = 1'b0;
      req       = 4'b1011;
`ifdef ROUND_ROBIN_EN
      held = 2'd1;
      exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
`else
      held = 2'd0;
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
`endif
      tick;
      req = 4'b0000;
      tick;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== held) begin
            n_fail++;
            $display("[TB] FAIL t2_stall: cycle %0d got valid=%b addr=%0d, want valid=1 addr=%0d", i, out_valid, out_addr, held);
         end
         tick;
      end
      out_ready = 1'b1;
      while (exp_q.size() > 0) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL t2_grant: got valid=%b addr=%0d, want valid=1 addr=%0d", out_valid, out_addr, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick;
      end
      n_checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL t2_idle: got valid=%b pend=%b, want valid=0 pend=0000", out_valid, pending);
      end
   endtask

   task automatic test_overrun;
      int ov_count;
      ov_count = 0;
      do_reset;
      enable    = 1'b1;
      out_ready = 1'b0;
      req       = 4'b0001;
      exp_q.push_back(2'd0);
      tick;
      req = 4'b0000;
      tick;
      req = 4'b0010;
      exp_q.push_back(2'd1);
      tick;
      ov_count += int'(overrun);
      req = 4'b0000;
      tick;
      ov_count += int'(overrun);
      req = 4'b0010;
      tick;
      ov_count += int'(overrun);
      req = 4'b0000;
      tick;
      ov_count += int'(overrun);
      tick;
      ov_count += int'(overrun);
      n_checks++;
      if (ov_count !== 1) begin
         n_fail++;
         $display("[TB] FAIL t3_overrun_pulse: got %0d high cycles, want 1", ov_count);
      end
      n_checks++;
      if (pending !== 4'b0010 || out_addr !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL t3_held: got pend=%b addr=%0d, want pend=0010 addr=0", pending, out_addr);
      end
      out_ready = 1'b1;
      while (exp_q.size() > 0) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL t3_grant: got valid=%b addr=%0d, want valid=1 addr=%0d", out_valid, out_addr, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick;
      end
      tick;
      n_checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000 || overrun !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL t3_once: got valid=%b pend=%b ovr=%b, want 0 0000 0", out_valid, pending, overrun);
      end
   endtask

   task automatic test_enable_freeze;
      logic [1:0] held_addr;
      logic [3:0] held_pend;
      do_reset;
      enable    = 1'b1;
      out_ready = 1'b0;
      req       = 4'b0111;
`ifdef ROUND_ROBIN_EN
      held_addr = 2'd1;
      held_pend = 4'b0101;
`else
      held_addr = 2'd0;
      held_pend = 4'b0110;
`endif
      tick;
      req = 4'b0000;
      tick;
      n_checks++;
      if (out_valid !== 1'b1 || out_addr !== held_addr || pending !== held_pend) begin
         n_fail++;
         $display("[TB] FAIL t4_setup: got valid=%b addr=%0d pend=%b, want 1 %0d %b", out_valid, out_addr, pending, held_addr, held_pend);
      end
      enable    = 1'b0;
      out_ready = 1'b1;
      req       = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== held_addr || pending !== held_pend || overrun !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL t4_frozen: cycle %0d got valid=%b addr=%0d pend=%b ovr=%b, want 1 %0d %b 0",
                     i, out_valid, out_addr, pending, overrun, held_addr, held_pend);
         end
      end
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
`else
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
`endif
      enable = 1'b1;
      while (exp_q.size() > 0) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL t4_grant: got valid=%b addr=%0d, want valid=1 addr=%0d", out_valid, out_addr, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick;
      end
      req = 4'b0000;
      n_checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL t4_idle: got valid=%b pend=%b, want valid=0 pend=0000", out_valid, pending);
      end
   endtask

   task automatic test_async_reset;
      do_reset;
      enable    = 1'b1;
      out_ready = 1'b0;
      req       = 4'b0011;
      tick;
      req = 4'b0000;
      tick;
      n_checks++;
      if (out_valid !== 1'b1 || pending === 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL t5_setup: got valid=%b pend=%b, want valid=1 pend nonzero", out_valid, pending);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000 || overrun !== 1'b0 || out_addr !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL t5_async: got valid=%b pend=%b ovr=%b addr=%0d, want all 0", out_valid, pending, overrun, out_addr);
      end
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      do_reset;
      enable    = 1'b1;
      out_ready = 1'b1;
      req       = 4'b1111;
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
`else
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
`endif
      tick;
      req = 4'b0000;
      tick;
      while (exp_q.size() > 0) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_addr !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL t6_grant: got valid=%b addr=%0d, want valid=1 addr=%0d", out_valid, out_addr, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick;
      end
      n_checks++;
      if (out_valid !== 1'b0 || pending !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL t6_idle: got valid=%b pend=%b, want valid=0 pend=0000", out_valid, pending);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset;
      test_single_event;
      test_stall_priority;
      test_overrun;
      test_enable_freeze;
      test_async_reset;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
